// File: rtl/x_micro_sequencer_pkg.sv
// Shared types for the micro-sequencer.
//   cmd_t   : instruction command codes (low field of each program word)
//   state_t : sequencer FSM states
package x_micro_sequencer_pkg;

  localparam int unsigned CMD_W_PKG = 4;

  typedef enum logic [CMD_W_PKG-1:0] {
    CMD_NOP  = 4'd0,
    CMD_OUT  = 4'd1,
    CMD_WAIT = 4'd2,
    CMD_JMP  = 4'd3,
    CMD_LOOP = 4'd4,
    CMD_HALT = 4'd5
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/x_micro_sequencer_ram_p.sv
// Program store for the micro-sequencer: simple dual-port RAM with one write
// port (A) and one registered read port (B, 1-cycle latency). No reset; contents
// are undefined until written.
//   i_clk   : clock
//   i_wen   : port A write enable (already gated by the caller)
//   i_waddr : port A address
//   i_wdata : port A data
//   i_raddr : port B address
//   o_rdata : port B data, registered
module x_micro_sequencer_ram_p #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      mem[i_waddr] <= i_wdata;
    end
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/x_micro_sequencer_p.sv
// Parametrised micro-sequencer. The host loads {data, cmd} words into the
// program RAM while idle; i_start runs the program from address 0 until HALT
// or i_abort. o_data drives the delay-line control datapath.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_abort    : run / stop controls
//   i_wen, i_wcmd,
//   i_wdata, i_waddr    : program write port (dropped while busy)
//   o_busy              : sequence running
//   o_done              : 1-cycle pulse as HALT executes
//   o_werr              : 1-cycle pulse after a write dropped while busy
//   o_valid, o_data     : output strobe and held output value
//   o_pc                : current program counter
module x_micro_sequencer_p
  import x_micro_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_wen,
  input  logic [CMD_W-1:0]  i_wcmd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_waddr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_werr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int unsigned WORD_W = DATA_W + CMD_W;
  localparam int unsigned CNT_W  = DATA_W - ADDR_W;

  localparam logic [CMD_W-1:0] C_OUT  = CMD_W'(CMD_OUT);
  localparam logic [CMD_W-1:0] C_WAIT = CMD_W'(CMD_WAIT);
  localparam logic [CMD_W-1:0] C_JMP  = CMD_W'(CMD_JMP);
  localparam logic [CMD_W-1:0] C_LOOP = CMD_W'(CMD_LOOP);
  localparam logic [CMD_W-1:0] C_HALT = CMD_W'(CMD_HALT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    lcnt_q, lcnt_d;
  logic                lact_q, lact_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                werr_q, werr_d;
  logic                done_c;

  logic                ram_wen;
  logic [WORD_W-1:0]   ram_rdata;
  logic [CMD_W-1:0]    ins_cmd;
  logic [DATA_W-1:0]   ins_data;
  logic [CNT_W-1:0]    loop_n;
  logic [ADDR_W-1:0]   loop_t;
  logic [ADDR_W-1:0]   pc_inc;

  // Writes only land while idle; a start in the same cycle still fetches the
  // new word because the read happens on the following (FETCH) edge.
  assign ram_wen = i_wen && (state_q == ST_IDLE);

  x_micro_sequencer_ram_p #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_wen   (ram_wen),
    .i_waddr (i_waddr),
    .i_wdata ({i_wdata, i_wcmd}),
    .i_raddr (pc_q),
    .o_rdata (ram_rdata)
  );

  assign ins_cmd  = ram_rdata[CMD_W-1:0];
  assign ins_data = ram_rdata[WORD_W-1:CMD_W];
  assign loop_n   = ins_data[DATA_W-1:ADDR_W];
  assign loop_t   = ins_data[ADDR_W-1:0];
  assign pc_inc   = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    lact_d  = lact_q;
    data_d  = data_q;
    valid_d = 1'b0;
    werr_d  = i_wen && (state_q != ST_IDLE);
    done_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (ins_cmd)
          C_OUT: begin
            data_d  = ins_data;
            valid_d = 1'b1;
          end
          C_WAIT: begin
            if (ins_data != '0) begin
              wcnt_d  = ins_data;
              pc_d    = pc_q;
              state_d = ST_WAIT;
            end
          end
          C_JMP: pc_d = loop_t;
          C_LOOP: begin
            // Single counter: first visit loads N-1 and branches, later visits
            // count down, the visit at zero falls through and disarms.
            if (!lact_q) begin
              if (loop_n != '0) begin
                lcnt_d = loop_n - CNT_W'(1);
                lact_d = 1'b1;
                pc_d   = loop_t;
              end
            end else if (lcnt_q == '0) begin
              lact_d = 1'b0;
            end else begin
              lcnt_d = lcnt_q - CNT_W'(1);
              pc_d   = loop_t;
            end
          end
          C_HALT: begin
            done_c  = 1'b1;
            pc_d    = pc_q;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end

      ST_WAIT: begin
        if (wcnt_q <= DATA_W'(1)) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          wcnt_d = wcnt_q - DATA_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever EXEC decided this cycle.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pc_d    = pc_q;
      wcnt_d  = wcnt_q;
      lcnt_d  = lcnt_q;
      lact_d  = 1'b0;
      data_d  = data_q;
      valid_d = 1'b0;
      done_c  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      lact_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      lact_q  <= lact_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      werr_q  <= werr_d;
    end
  end

  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_c;
  assign o_werr  = werr_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_pc    = pc_q;

endmodule
